// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier that borrows the shared ALU for REG_WIDTH add steps.
// Optional: define ALU_MUL_ZERO_BYPASS_EN to finish zero-operand requests without running the ALU.
module alu_mul_seq #(
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = $clog2(REG_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 start,
  input  logic [REG_WIDTH-1:0] op_a,
  input  logic [REG_WIDTH-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic [REG_WIDTH-1:0] prod_hi,
  output logic [REG_WIDTH-1:0] prod_lo,
  output logic [REG_WIDTH-1:0] alu_in1,
  output logic [REG_WIDTH-1:0] alu_in2,
  output logic [3:0]           alu_control,
  input  logic [REG_WIDTH-1:0] alu_result
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_t;

  localparam logic [3:0]           AluAdd  = 4'b0010;
  localparam logic [3:0]           AluNop  = 4'b0000;
  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(REG_WIDTH - 1);

  state_t               r_state, w_state_d;
  logic [REG_WIDTH-1:0] r_mcand, w_mcand_d;
  logic [REG_WIDTH-1:0] r_acc, w_acc_d;
  logic [REG_WIDTH-1:0] r_mplr, w_mplr_d;
  logic [REG_WIDTH-1:0] r_prod_hi, w_prod_hi_d;
  logic [REG_WIDTH-1:0] r_prod_lo, w_prod_lo_d;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_d;
  logic                 w_carry;

  always_comb begin
    alu_control = AluNop;
    alu_in1     = '0;
    alu_in2     = '0;
    if (r_state == StRun) begin
      alu_control = AluAdd;
      alu_in1     = r_acc;
      alu_in2     = r_mplr[0] ? r_mcand : '0;
    end
  end

  // The ALU add wraps at REG_WIDTH bits; a wrapped sum is smaller than its first operand.
  assign w_carry = (alu_result < alu_in1);

  always_comb begin
    w_state_d   = r_state;
    w_mcand_d   = r_mcand;
    w_acc_d     = r_acc;
    w_mplr_d    = r_mplr;
    w_cnt_d     = r_cnt;
    w_prod_hi_d = r_prod_hi;
    w_prod_lo_d = r_prod_lo;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_mcand_d = op_a;
          w_mplr_d  = op_b;
          w_acc_d   = '0;
          w_cnt_d   = '0;
          w_state_d = StRun;
`ifdef ALU_MUL_ZERO_BYPASS_EN
          if ((op_a == '0) || (op_b == '0)) begin
            w_mcand_d   = '0;
            w_mplr_d    = '0;
            w_prod_hi_d = '0;
            w_prod_lo_d = '0;
            w_state_d   = StDone;
          end
`endif
        end
      end
      StRun: begin
        w_acc_d  = {w_carry, alu_result[REG_WIDTH-1:1]};
        w_mplr_d = {alu_result[0], r_mplr[REG_WIDTH-1:1]};
        if (r_cnt == LastCnt) begin
          // Product is loaded on the edge entering DONE so it is valid alongside the done pulse.
          w_prod_hi_d = w_acc_d;
          w_prod_lo_d = w_mplr_d;
          w_state_d   = StDone;
        end else begin
          w_cnt_d = r_cnt + CNT_WIDTH'(1);
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state   <= StIdle;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplr    <= '0;
      r_cnt     <= '0;
      r_prod_hi <= '0;
      r_prod_lo <= '0;
    end else begin
      r_state   <= w_state_d;
      r_mcand   <= w_mcand_d;
      r_acc     <= w_acc_d;
      r_mplr    <= w_mplr_d;
      r_cnt     <= w_cnt_d;
      r_prod_hi <= w_prod_hi_d;
      r_prod_lo <= w_prod_lo_d;
    end
  end

  assign busy    = (r_state != StIdle);
  assign done    = (r_state == StDone);
  assign prod_hi = r_prod_hi;
  assign prod_lo = r_prod_lo;

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Iterative unsigned multiplier controller that sequences the shared integer ALU through REG_WIDTH add steps to form a 2*REG_WIDTH-bit product.
- Sits beside the ALU in the execute stage.
- Drives the ALU operand/control inputs while busy and consumes the ALU result combinationally.
- Start/busy/done handshake toward the core control unit.

Parameters:
- REG_WIDTH, 32, operand width; equals the ALU and register-file width.
- CNT_WIDTH, $clog2(REG_WIDTH)+1, step-counter width.

Ports:
- clk  input  1  system clock, rising edge
- reset_b  input  1  asynchronous active-low reset
- start  input  1  request; accepted only in IDLE
- op_a  input  REG_WIDTH  multiplicand, sampled on accept
- op_b  input  REG_WIDTH  multiplier, sampled on accept
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; product valid
- prod_hi  output  REG_WIDTH  upper product half, registered
- prod_lo  output  REG_WIDTH  lower product half, registered
- alu_in1  output  REG_WIDTH  to ALU operand 1
- alu_in2  output  REG_WIDTH  to ALU operand 2
- alu_control  output  4  to ALU control
- alu_result  input  REG_WIDTH  from ALU result

Behaviour:
- Reset (async, reset_b=0):
  - State forced to IDLE.
  - busy, done, prod_hi, prod_lo, step counter, internal mcand/acc/mplr registers all cleared to 0.
- Registers:
  - mcand: REG_WIDTH.
  - acc: REG_WIDTH, which is the product-hi working register.
  - mplr: REG_WIDTH, which is the product-lo working register.
  - cnt: CNT_WIDTH.
- States:
  - IDLE: start=1 -> latch mcand=op_a, mplr=op_b, acc=0, cnt=0; go to RUN. start=0 -> stay.
  - RUN: one step per cycle. cnt==REG_WIDTH-1 on a step -> go to DONE after that step. Otherwise stay with cnt+1.
  - DONE: done=1 for exactly this cycle; prod_hi/prod_lo load acc/mplr. Next state is always IDLE.
- ALU drive, combinational:
  - RUN: alu_control=4'b0010 (add), alu_in1=acc, alu_in2 = mplr[0] ? mcand : 0.
  - Not in RUN: alu_control=4'b0000, alu_in1=0, alu_in2=0.
- Step in RUN:
  - carry = (alu_result < alu_in1), unsigned compare.
  - {acc, mplr} <= {carry, alu_result, mplr[REG_WIDTH-1:1]}, i.e. a 2W+1-bit value shifted right by 1.
- Latency:
  - start accepted on edge N -> done high during cycle N+REG_WIDTH+1.
  - Next start can be accepted at N+REG_WIDTH+2.
- busy=1 in RUN and DONE; 0 in IDLE.
- start while busy: ignored; no effect on in-flight operation or outputs.
- prod_hi/prod_lo:
  - Hold their last value until the next DONE.
  - Unchanged on start accept.
- Operands: op_a/op_b are don't-care after the accept edge.
- Reset mid-operation: the operation is aborted; no done pulse; all outputs per reset values.
- Arithmetic: unsigned only; no overflow is possible (full 2W-bit result).

Optional Feature:
- Macro: ALU_MUL_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, a start with op_a==0 or op_b==0 goes directly to DONE and skips RUN.
  - done appears during cycle N+1 with prod_hi=prod_lo=0.
  - The ALU is never driven for that operation; busy is high only in the DONE cycle.
- Not defined:
  - Zero operands take the full REG_WIDTH-step RUN path.
  - The result is still 0 and the latency is identical to non-zero operands.

Test Plan:
- REG_WIDTH=32, op_a=3, op_b=5, start 1 cycle -> done exactly 33 cycles after accept; prod_hi=0, prod_lo=15; busy high for 33 cycles.
- op_a=op_b=32'hFFFFFFFF -> prod_hi=32'hFFFFFFFE, prod_lo=32'h00000001; exercises the carry path every step.
- op_a=32'h80000000, op_b=2; pulse start=1 with op_a=7 at RUN step 10 -> second start ignored; prod_hi=1, prod_lo=0; single done pulse.
- Start op_a=9, op_b=9; assert reset_b=0 at RUN step 5 for 1 cycle -> busy=0 and prod=0 immediately, no done. Then op 9*9 -> prod_lo=81.
- During any RUN: alu_control==4'b0010 every cycle; alu_in2==0 on steps where the multiplier LSB is 0 (op_b=32'hAAAAAAAA: even steps). In IDLE, alu_control==0.
- op_a=0, op_b=123 -> with ALU_MUL_ZERO_BYPASS_EN: done 1 cycle after accept, prod=0. Without the macro: done after 33 cycles, prod=0.
